// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: opcode field width, opcode constants, fetch FSM states.
// Pure declarations; no timing or flow-control behaviour of its own.
package cpu_pkg;

    localparam int OPC_W       = 6;
    localparam int INSTR_W_DEF = 32;
    localparam int ADDR_W_DEF  = 8;

    localparam logic [OPC_W-1:0] OPC_ALU   = 6'd1;
    localparam logic [OPC_W-1:0] OPC_STORE = 6'd3;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_DRAIN
    } fetch_state_e;

endpackage

// File: rtl/ifetch_skid.sv
// Single-entry {pc, instr} holding buffer behind the fetch IR; load/pop take effect next cycle.
// No backpressure of its own: the owner never loads while occupied; clear wins over load and pop.
module ifetch_skid #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               pop,
    input  logic               clear,
    input  logic [ADDR_W-1:0]  load_pc,
    input  logic [INSTR_W-1:0] load_instr,
    output logic               occupied,
    output logic [ADDR_W-1:0]  skid_pc,
    output logic [INSTR_W-1:0] skid_instr
);

    always_ff @(posedge clk) begin
        if (reset) begin
            occupied   <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            if (clear) begin
                occupied <= 1'b0;
            end else if (load) begin
                occupied <= 1'b1;
            end else if (pop) begin
                occupied <= 1'b0;
            end
            if (load && !clear) begin
                skid_pc    <= load_pc;
                skid_instr <= load_instr;
            end
        end
    end

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: PC + imem req/ack FSM feeding an IR with a one-entry skid; IR valid 1 cycle after ack.
// Stall holds IR/skid and halts requests once the skid fills; redirect flushes. IFETCH_PERF_EN adds counters.
import cpu_pkg::*;

module ifetch_stage #(
    parameter int                ADDR_W   = ADDR_W_DEF,
    parameter int                INSTR_W  = INSTR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
`ifdef IFETCH_PERF_EN
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_stall_cyc,
`endif
    output logic [OPC_W-1:0]   if_opc
);

    fetch_state_e       state, state_nxt;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  drain_addr;
    logic               ack_fire;
    logic               consume;
    logic               ir_free;
    logic               skid_occ;
    logic               skid_load;
    logic               skid_pop;
    logic [ADDR_W-1:0]  skid_pc;
    logic [INSTR_W-1:0] skid_instr;

    assign ack_fire  = imem_ack && (state == FETCH_REQ);
    assign consume   = if_valid && !stall;
    assign ir_free   = !if_valid || !stall;
    assign skid_load = ack_fire && !ir_free && !redirect;
    assign skid_pop  = consume && !redirect;

    // A drained request must keep presenting the address it was issued with.
    assign imem_req  = (state != FETCH_IDLE);
    assign imem_addr = (state == FETCH_DRAIN) ? drain_addr : pc;
    assign if_opc    = if_instr[INSTR_W-1 -: OPC_W];

    ifetch_skid #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .pop        (skid_pop),
        .clear      (redirect),
        .load_pc    (pc),
        .load_instr (imem_rdata),
        .occupied   (skid_occ),
        .skid_pc    (skid_pc),
        .skid_instr (skid_instr)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH_IDLE: begin
                if (redirect || !skid_occ) state_nxt = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (redirect)                    state_nxt = imem_ack ? FETCH_REQ : FETCH_DRAIN;
                else if (imem_ack && !ir_free)   state_nxt = FETCH_IDLE;
            end
            FETCH_DRAIN: begin
                if (imem_ack) state_nxt = FETCH_REQ;
            end
            default: state_nxt = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH_IDLE;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc <= redirect_pc;
            end else if (ack_fire) begin
                pc <= pc + 1'b1;
            end
            if (redirect && (state == FETCH_REQ) && !imem_ack) begin
                drain_addr <= pc;
            end
            // Skid is always older than a response arriving in the same cycle.
            if (redirect) begin
                if_valid <= 1'b0;
            end else if (consume && skid_occ) begin
                if_valid <= 1'b1;
                if_pc    <= skid_pc;
                if_instr <= skid_instr;
            end else if (ack_fire && ir_free) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_instr <= imem_rdata;
            end else if (consume) begin
                if_valid <= 1'b0;
            end
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (consume)           perf_fetched   <= perf_fetched + 32'd1;
            if (if_valid && stall) perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_stage.sv
// Bench for ifetch_stage: directed fetch/stall/redirect/wrap/reset scenarios, then randomized
// stall/redirect/reset/memory latency checked against an in-order instruction stream model.
module tb_ifetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [7:0]  if_pc;
    logic [5:0]  if_opc;

    ifetch_stage dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_opc      (if_opc)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    // Instruction memory contents: word at address a.
    function automatic logic [31:0] memf(input logic [7:0] a);
        logic [5:0] lo;
        lo = a[5:0];
        return {lo ^ 6'd1, 2'b00, 8'h00, a, a};
    endfunction

    // Reference model: the next instruction address the downstream must see.
    logic [7:0]  exp_pc;
    int          mem_wait = 0;
    int          lat_max  = 0;
    int          idle_cyc = 0;
    bit          have_prev = 1'b0;
    logic        p_reset, p_redirect, p_valid, p_stall, p_req, p_ack;
    logic [7:0]  p_pc, p_addr;
    logic [31:0] p_instr;

    task automatic cyc();
        logic [31:0] want;
        @(negedge clk);
        if (have_prev) begin
            if (p_reset) begin
                expect_eq("rst_req", 32'(imem_req), 32'd0);
                expect_eq("rst_vld", 32'(if_valid), 32'd0);
            end else begin
                if (p_redirect) begin
                    expect_eq("flush_vld", 32'(if_valid), 32'd0);
                end else if (p_valid && p_stall) begin
                    expect_eq("hold_vld", 32'(if_valid), 32'd1);
                    expect_eq("hold_pc", 32'(if_pc), 32'(p_pc));
                    expect_eq("hold_instr", if_instr, p_instr);
                end
                if (p_req && !p_ack) begin
                    expect_eq("req_hold", 32'(imem_req), 32'd1);
                    expect_eq("addr_hold", 32'(imem_addr), 32'(p_addr));
                end
            end
        end
        if (reset) begin
            exp_pc   = 8'h00;
            idle_cyc = 0;
        end else begin
            if (if_valid && !stall) begin
                want = memf(exp_pc);
                expect_eq("cons_pc", 32'(if_pc), 32'(exp_pc));
                expect_eq("cons_instr", if_instr, want);
                expect_eq("cons_opc", 32'(if_opc), 32'(want[31:26]));
                exp_pc   = exp_pc + 8'd1;
                idle_cyc = 0;
            end else if (!(if_valid && stall)) begin
                idle_cyc++;
            end
            if (idle_cyc > 25) begin
                expect_eq("progress", 32'(idle_cyc), 32'd0);
                idle_cyc = 0;
            end
            if (redirect) begin
                exp_pc   = redirect_pc;
                idle_cyc = 0;
            end
        end
        if (imem_req) begin
            if (mem_wait == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = memf(imem_addr);
                mem_wait   = $urandom_range(0, lat_max);
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = $urandom;
                mem_wait--;
            end
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = $urandom;
            mem_wait   = $urandom_range(0, lat_max);
        end
        p_reset    = reset;
        p_redirect = redirect;
        p_valid    = if_valid;
        p_stall    = stall;
        p_req      = imem_req;
        p_ack      = imem_ack;
        p_pc       = if_pc;
        p_addr     = imem_addr;
        p_instr    = if_instr;
        have_prev  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        exp_pc      = 8'h00;

        // Reset, then zero-wait fetch from address 0.
        cyc();
        cyc();
        expect_eq("rst_req0", 32'(imem_req), 32'd0);
        expect_eq("rst_vld0", 32'(if_valid), 32'd0);
        expect_eq("rst_instr0", if_instr, 32'd0);
        expect_eq("rst_pc0", 32'(if_pc), 32'd0);
        reset = 1'b0;
        cyc();
        expect_eq("first_req", 32'(imem_req), 32'd1);
        expect_eq("first_addr", 32'(imem_addr), 32'd0);
        expect_eq("first_vld", 32'(if_valid), 32'd0);
        cyc();
        expect_eq("t1_vld", 32'(if_valid), 32'd1);
        expect_eq("t1_pc", 32'(if_pc), 32'd0);
        expect_eq("t1_opc", 32'(if_opc), 32'd1);
        expect_eq("t1_instr", if_instr, 32'h0400_0000);
        expect_eq("t1_addr", 32'(imem_addr), 32'd1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            expect_eq("stream_pc", 32'(if_pc), 32'(k));
            expect_eq("stream_addr", 32'(imem_addr), 32'(k + 1));
            expect_eq("stream_vld", 32'(if_valid), 32'd1);
        end

        // Stall with addr 4 in IR while addr 5 returns.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            expect_eq("stall_pc", 32'(if_pc), 32'd4);
            expect_eq("stall_noreq", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        cyc();
        expect_eq("skid_out_pc", 32'(if_pc), 32'd5);
        expect_eq("skid_out_vld", 32'(if_valid), 32'd1);
        cyc();
        expect_eq("resume_req", 32'(imem_req), 32'd1);
        expect_eq("resume_addr", 32'(imem_addr), 32'd6);
        cyc();
        expect_eq("resume_pc", 32'(if_pc), 32'd6);

        // Redirect while the addr-7 request waits: drain then fetch 0x40.
        mem_wait    = 2;
        redirect    = 1'b1;
        redirect_pc = 8'h40;
        cyc();
        redirect = 1'b0;
        expect_eq("drain_vld", 32'(if_valid), 32'd0);
        expect_eq("drain_addr", 32'(imem_addr), 32'd7);
        cyc();
        expect_eq("drain_addr2", 32'(imem_addr), 32'd7);
        cyc();
        expect_eq("tgt_req", 32'(imem_req), 32'd1);
        expect_eq("tgt_addr", 32'(imem_addr), 32'h40);
        expect_eq("tgt_vld0", 32'(if_valid), 32'd0);
        cyc();
        expect_eq("tgt_pc", 32'(if_pc), 32'h40);
        expect_eq("tgt_vld", 32'(if_valid), 32'd1);

        // Redirect with coincident ack under stall.
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 8'h80;
        cyc();
        expect_eq("rdack_vld", 32'(if_valid), 32'd0);
        expect_eq("rdack_addr", 32'(imem_addr), 32'h80);
        stall    = 1'b0;
        redirect = 1'b0;
        cyc();
        expect_eq("rdack_pc", 32'(if_pc), 32'h80);

        // Redirect with skid full under stall.
        stall = 1'b1;
        cyc();
        expect_eq("full_noreq", 32'(imem_req), 32'd0);
        redirect    = 1'b1;
        redirect_pc = 8'h90;
        cyc();
        expect_eq("full_flush_vld", 32'(if_valid), 32'd0);
        expect_eq("full_flush_addr", 32'(imem_addr), 32'h90);
        stall    = 1'b0;
        redirect = 1'b0;
        cyc();
        expect_eq("full_tgt_pc", 32'(if_pc), 32'h90);

        // PC wrap at 0xFF.
        redirect    = 1'b1;
        redirect_pc = 8'hFD;
        cyc();
        redirect = 1'b0;
        expect_eq("wrap_fd", 32'(imem_addr), 32'hFD);
        cyc();
        cyc();
        expect_eq("wrap_ff", 32'(imem_addr), 32'hFF);
        cyc();
        expect_eq("wrap_00", 32'(imem_addr), 32'h00);
        cyc();
        expect_eq("wrap_pc", 32'(if_pc), 32'h00);

        // Reset mid-request.
        mem_wait = 3;
        cyc();
        expect_eq("mid_req", 32'(imem_req), 32'd1);
        reset = 1'b1;
        cyc();
        expect_eq("mid_rst_req", 32'(imem_req), 32'd0);
        expect_eq("mid_rst_vld", 32'(if_valid), 32'd0);
        reset = 1'b0;
        cyc();
        expect_eq("mid_resume_addr", 32'(imem_addr), 32'd0);
        cyc();
        expect_eq("mid_resume_pc", 32'(if_pc), 32'd0);
        expect_eq("mid_resume_vld", 32'(if_valid), 32'd1);

        // Randomized traffic.
        lat_max = 3;
        for (int n = 0; n < 3000; n++) begin
            stall       = ($urandom_range(0, 3) == 0);
            redirect    = ($urandom_range(0, 30) == 0);
            redirect_pc = 8'($urandom);
            reset       = ($urandom_range(0, 400) == 0);
            cyc();
        end
        stall    = 1'b0;
        redirect = 1'b0;
        reset    = 1'b0;
        for (int n = 0; n < 10; n++) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
